memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
- MEM pipeline stage; the consumer end of the Execute-stage result interface.
- Latches Execute outputs (ALU result, zero flag, branch target, store data, destination register) plus MEM/WB control into an EX/MEM register.
- Performs word load/store on an internal data memory with configurable multi-cycle latency, stalling upstream while busy.
- Resolves branches and drives a registered MEM/WB bundle to writeback.

Parameters:
- DATA_WIDTH, 32, data/address width.
- ADDR_WIDTH, 8, word-address bits; memory depth = 2^ADDR_WIDTH words.
- MEM_LATENCY, 2, cycles per memory access (legal range >= 1).

Ports:
- clock  input  1  single clock; all state on rising edge.
- resetN  input  1  asynchronous, active-low reset.
- inValid  input  1  Execute presents a valid instruction.
- ALUResult  input  DATA_WIDTH  ALU result / byte address.
- zero  input  1  ALU zero flag.
- addResult  input  DATA_WIDTH  branch target from Execute.
- aluReadDataTwo  input  DATA_WIDTH  store data.
- RdOrRt  input  5  destination register.
- memRead  input  1  load.
- memWrite  input  1  store.
- branch  input  1  beq-type branch.
- regWrite  input  1  writeback enable, passed through.
- memToReg  input  1  writeback select, passed through.
- stall  output  1  upstream must hold; EX/MEM does not capture.
- pcSrc  output  1  taken branch.
- branchTarget  output  DATA_WIDTH  latched addResult.
- memError  output  1  one-cycle pulse on misaligned access.
- wbValid  output  1  MEM/WB valid.
- wbRegWrite  output  1  MEM/WB regWrite, forced 0 on memError.
- wbMemToReg  output  1  MEM/WB memToReg.
- wbReadData  output  DATA_WIDTH  load data.
- wbAluResult  output  DATA_WIDTH  latched ALUResult.
- wbRegister  output  5  latched RdOrRt.

Behaviour:
- Reset (resetN low, asynchronous):
  - All EX/MEM and MEM/WB registers, the counter and the FSM clear to 0 / IDLE.
  - Outputs: stall=0, pcSrc=0, memError=0, all wb* = 0, branchTarget = 0.
  - Memory contents are not reset.
  - Reset mid-access abandons the access; a pending store is not written.
- EX/MEM capture:
  - On each edge with stall=0, all inputs are captured; exMemValid <= inValid.
  - With stall=1, EX/MEM holds.
- Address decode:
  - wordAddr = EX/MEM ALUResult[ADDR_WIDTH+1:2].
  - Upper bits are ignored, so addresses wrap modulo depth.
  - misaligned = ALUResult[1:0] != 0.
- memOp = exMemValid & (memRead | memWrite) & ~misaligned.
  - memRead and memWrite both set: store takes precedence, and the read returns the old word.
- FSM (IDLE, ACCESS):
  - IDLE, memOp and MEM_LATENCY > 1: -> ACCESS, counter = 0.
  - ACCESS: counter increments each edge. Complete when counter == MEM_LATENCY-2, i.e. at the edge MEM_LATENCY cycles after the capture edge; then -> IDLE.
  - Combinational stall = memOp & ~completing_this_cycle. MEM_LATENCY=1 never stalls.
- Completion edge:
  - Store: writes aluReadDataTwo to mem[wordAddr].
  - Load: registers mem[wordAddr] into wbReadData.
  - MEM/WB loads {wbValid=1, regWrite, memToReg, ALUResult, RdOrRt}.
  - EX/MEM captures the next instruction on the same edge.
- Non-memory instructions: MEM/WB is loaded at the edge after capture (latency 1); wbReadData holds its previous value.
- wbValid: if EX/MEM is invalid or still stalling, the edge loads wbValid=0 (bubble); other wb* fields hold.
- Misaligned memRead/memWrite:
  - No memory access and no stall.
  - memError pulses for 1 cycle, registered together with MEM/WB.
  - wbValid=1 with wbRegWrite=0.
- Branch:
  - pcSrc = exMemValid & branch & zero (combinational from EX/MEM), asserted for exactly one cycle.
  - branchTarget = EX/MEM addResult.
  - A branch is never a memOp, so pcSrc never coincides with stall.
- Back-to-back memory ops: each costs MEM_LATENCY cycles, with no extra idle cycle between them.

Test Plan:
- Reset mid-ACCESS:
  - Stimulus: MEM_LATENCY=3; store 0xDEADBEEF to addr 0x10; drop resetN in cycle 2.
  - Required: stall=0 and all wb*=0 immediately; mem[4] unchanged; after release, reading 0x10 returns the old value.
- Store then load:
  - Stimulus: MEM_LATENCY=2; store 0x12345678 @0x20, then load @0x20 to RdOrRt=5.
  - Required: stall high 1 cycle per op; load gives wbReadData=0x12345678, wbRegister=5, wbMemToReg=1.
- ALU op, no stall:
  - Stimulus: ALUResult=0x7, regWrite=1, RdOrRt=9.
  - Required: next edge wbAluResult=0x7, wbRegister=9, wbValid=1; stall never high.
- Branch:
  - Stimulus: branch=1 with zero=1, addResult=0x400.
  - Required: pcSrc=1 for one cycle, branchTarget=0x400.
  - Stimulus: same with zero=0.
  - Required: pcSrc stays 0.
- Misaligned load and address wrap:
  - Stimulus: load @0x22.
  - Required: memError pulse, wbRegWrite=0, no stall.
  - Stimulus: ADDR_WIDTH=8; store @0x404, then load @0x004.
  - Required: load returns the stored word.
- MEM_LATENCY=1, consecutive loads:
  - Stimulus: back-to-back loads @0x0, 0x4, 0x8.
  - Required: stall never asserted; wbReadData updates on three consecutive edges.

Source files
------------

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: EX/MEM register, multi-cycle word data memory with upstream stall,
// branch resolution and a registered MEM/WB bundle.
module memory_access_stage #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  inValid,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic                  zero,
  input  logic [DATA_WIDTH-1:0] addResult,
  input  logic [DATA_WIDTH-1:0] aluReadDataTwo,
  input  logic [4:0]            RdOrRt,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  branch,
  input  logic                  regWrite,
  input  logic                  memToReg,
  output logic                  stall,
  output logic                  pcSrc,
  output logic [DATA_WIDTH-1:0] branchTarget,
  output logic                  memError,
  output logic                  wbValid,
  output logic                  wbRegWrite,
  output logic                  wbMemToReg,
  output logic [DATA_WIDTH-1:0] wbReadData,
  output logic [DATA_WIDTH-1:0] wbAluResult,
  output logic [4:0]            wbRegister
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LAST  = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;
  localparam int unsigned CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ex_valid_q, ex_zero_q, ex_read_q, ex_write_q;
  logic                    ex_branch_q, ex_reg_write_q, ex_mem_to_reg_q;
  logic [DATA_WIDTH-1:0]   ex_alu_q, ex_add_q, ex_store_q;
  logic [4:0]              ex_rd_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    req_c, misaligned_c, mem_op_c, last_c, done_c;
  logic [ADDR_WIDTH-1:0]   word_addr_c;

  // Access decode; upper address bits are dropped so addresses wrap modulo depth.
  always_comb begin
    word_addr_c  = ex_alu_q[ADDR_WIDTH+1:2];
    misaligned_c = |ex_alu_q[1:0];
    req_c        = ex_valid_q & (ex_read_q | ex_write_q);
    mem_op_c     = req_c & ~misaligned_c;
    last_c       = (MEM_LATENCY == 1) || ((state_q == ACCESS) && (cnt_q == CNT_W'(LAST)));
    done_c       = mem_op_c & last_c;
  end

  assign stall        = mem_op_c & ~last_c;
  assign pcSrc        = ex_valid_q & ex_branch_q & ex_zero_q;
  assign branchTarget = ex_add_q;

  // Access sequencer, EX/MEM capture and MEM/WB bundle.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      ex_valid_q      <= 1'b0;
      ex_zero_q       <= 1'b0;
      ex_read_q       <= 1'b0;
      ex_write_q      <= 1'b0;
      ex_branch_q     <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_alu_q        <= '0;
      ex_add_q        <= '0;
      ex_store_q      <= '0;
      ex_rd_q         <= '0;
      memError        <= 1'b0;
      wbValid         <= 1'b0;
      wbRegWrite      <= 1'b0;
      wbMemToReg      <= 1'b0;
      wbReadData      <= '0;
      wbAluResult     <= '0;
      wbRegister      <= '0;
    end else begin
      if (stall) begin
        if (state_q == IDLE) begin
          state_q <= ACCESS;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        state_q <= IDLE;
      end

      if (!stall && ex_valid_q) begin
        wbValid     <= 1'b1;
        wbRegWrite  <= ex_reg_write_q & ~(req_c & misaligned_c);
        memError    <= req_c & misaligned_c;
        wbMemToReg  <= ex_mem_to_reg_q;
        wbAluResult <= ex_alu_q;
        wbRegister  <= ex_rd_q;
        if (done_c && ex_read_q) wbReadData <= mem[word_addr_c];
      end else begin
        wbValid  <= 1'b0;
        memError <= 1'b0;
      end

      if (!stall) begin
        ex_valid_q      <= inValid;
        ex_zero_q       <= zero;
        ex_read_q       <= memRead;
        ex_write_q      <= memWrite;
        ex_branch_q     <= branch;
        ex_reg_write_q  <= regWrite;
        ex_mem_to_reg_q <= memToReg;
        ex_alu_q        <= ALUResult;
        ex_add_q        <= addResult;
        ex_store_q      <= aluReadDataTwo;
        ex_rd_q         <= RdOrRt;
      end
    end
  end

  // Data memory is not reset; a write only happens on the completion edge of a store.
  always_ff @(posedge clock) begin
    if (done_c && ex_write_q) mem[word_addr_c] <= ex_store_q;
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: three instances (latency 1, 2, 3) checked every cycle
// against a transaction-level model, plus literal expectations for directed scenarios.
module tb_memory_access_stage;

  logic clock = 1'b0;
  logic resetN = 1'b1;
  always #5 clock = ~clock;

  logic [2:0]  in_valid;
  logic [31:0] alu_in, add_in, sd_in;
  logic [4:0]  rd_in;
  logic        zero_in, mr_in, mw_in, br_in, rw_in, m2r_in;

  logic [2:0]  d_stall, d_pc, d_err, d_wv, d_wrw, d_wm2r;
  logic [31:0] d_bt [3];
  logic [31:0] d_rdata [3];
  logic [31:0] d_alu [3];
  logic [4:0]  d_reg [3];

  memory_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_LATENCY(1)) u_l1 (
    .clock(clock), .resetN(resetN), .inValid(in_valid[0]), .ALUResult(alu_in), .zero(zero_in),
    .addResult(add_in), .aluReadDataTwo(sd_in), .RdOrRt(rd_in), .memRead(mr_in), .memWrite(mw_in),
    .branch(br_in), .regWrite(rw_in), .memToReg(m2r_in), .stall(d_stall[0]), .pcSrc(d_pc[0]),
    .branchTarget(d_bt[0]), .memError(d_err[0]), .wbValid(d_wv[0]), .wbRegWrite(d_wrw[0]),
    .wbMemToReg(d_wm2r[0]), .wbReadData(d_rdata[0]), .wbAluResult(d_alu[0]), .wbRegister(d_reg[0]));

  memory_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_LATENCY(2)) u_l2 (
    .clock(clock), .resetN(resetN), .inValid(in_valid[1]), .ALUResult(alu_in), .zero(zero_in),
    .addResult(add_in), .aluReadDataTwo(sd_in), .RdOrRt(rd_in), .memRead(mr_in), .memWrite(mw_in),
    .branch(br_in), .regWrite(rw_in), .memToReg(m2r_in), .stall(d_stall[1]), .pcSrc(d_pc[1]),
    .branchTarget(d_bt[1]), .memError(d_err[1]), .wbValid(d_wv[1]), .wbRegWrite(d_wrw[1]),
    .wbMemToReg(d_wm2r[1]), .wbReadData(d_rdata[1]), .wbAluResult(d_alu[1]), .wbRegister(d_reg[1]));

  memory_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_LATENCY(3)) u_l3 (
    .clock(clock), .resetN(resetN), .inValid(in_valid[2]), .ALUResult(alu_in), .zero(zero_in),
    .addResult(add_in), .aluReadDataTwo(sd_in), .RdOrRt(rd_in), .memRead(mr_in), .memWrite(mw_in),
    .branch(br_in), .regWrite(rw_in), .memToReg(m2r_in), .stall(d_stall[2]), .pcSrc(d_pc[2]),
    .branchTarget(d_bt[2]), .memError(d_err[2]), .wbValid(d_wv[2]), .wbRegWrite(d_wrw[2]),
    .wbMemToReg(d_wm2r[2]), .wbReadData(d_rdata[2]), .wbAluResult(d_alu[2]), .wbRegister(d_reg[2]));

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (latency %0d) at %0t: got %h expected %h", name, k + 1, $time, act, exp);
    end
  endtask

  // Model: an instruction sits in the stage for LAT edges if it is an aligned memory op,
  // otherwise for one edge; the stage accepts a new one whenever the current one leaves.
  typedef struct {
    logic [31:0] alu, add, sd;
    logic [4:0]  rd;
    logic        zero, mr, mw, br, rw, m2r;
  } ins_t;

  ins_t        m_ins [3];
  bit          m_occ [3];
  int          m_age [3];
  logic [31:0] m_bt [3], m_rdata [3], m_alu [3];
  logic [4:0]  m_reg [3];
  logic        m_wv [3], m_wrw [3], m_wm2r [3], m_err [3];
  logic [31:0] m_mem [3][256];

  function automatic int need(input ins_t i, input int k);
    if ((i.mr || i.mw) && i.alu[1:0] == 2'b00) return k + 1;
    return 1;
  endfunction

  ins_t mc;
  bit   mfree, mmis, mop;
  int   midx;

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < 3; k++) begin
        m_occ[k] = 0; m_age[k] = 0; m_bt[k] = '0; m_rdata[k] = '0; m_alu[k] = '0;
        m_reg[k] = '0; m_wv[k] = 0; m_wrw[k] = 0; m_wm2r[k] = 0; m_err[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        mc = m_ins[k];
        mfree = !m_occ[k] || (m_age[k] + 1 >= need(mc, k));
        if (m_occ[k] && mfree) begin
          mmis = (mc.mr || mc.mw) && (mc.alu[1:0] != 2'b00);
          mop  = (mc.mr || mc.mw) && !mmis;
          midx = int'(mc.alu[9:2]);
          if (mop && mc.mr) m_rdata[k] = m_mem[k][midx];
          if (mop && mc.mw) m_mem[k][midx] = mc.sd;
          m_wv[k] = 1'b1; m_wrw[k] = mc.rw && !mmis; m_wm2r[k] = mc.m2r;
          m_alu[k] = mc.alu; m_reg[k] = mc.rd; m_err[k] = mmis;
        end else begin
          m_wv[k] = 1'b0; m_err[k] = 1'b0;
          if (m_occ[k]) m_age[k]++;
        end
        if (mfree) begin
          m_bt[k] = add_in; m_occ[k] = in_valid[k]; m_age[k] = 0;
          m_ins[k].alu = alu_in; m_ins[k].add = add_in; m_ins[k].sd = sd_in; m_ins[k].rd = rd_in;
          m_ins[k].zero = zero_in; m_ins[k].mr = mr_in; m_ins[k].mw = mw_in; m_ins[k].br = br_in;
          m_ins[k].rw = rw_in; m_ins[k].m2r = m2r_in;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check("stall",        k, 32'(d_stall[k]), 32'(m_occ[k] && (m_age[k] + 1 < need(m_ins[k], k))));
        check("pcSrc",        k, 32'(d_pc[k]),    32'(m_occ[k] && m_ins[k].br && m_ins[k].zero));
        check("branchTarget", k, d_bt[k],         m_bt[k]);
        check("memError",     k, 32'(d_err[k]),   32'(m_err[k]));
        check("wbValid",      k, 32'(d_wv[k]),    32'(m_wv[k]));
        check("wbRegWrite",   k, 32'(d_wrw[k]),   32'(m_wrw[k]));
        check("wbMemToReg",   k, 32'(d_wm2r[k]),  32'(m_wm2r[k]));
        check("wbReadData",   k, d_rdata[k],      m_rdata[k]);
        check("wbAluResult",  k, d_alu[k],        m_alu[k]);
        check("wbRegister",   k, 32'(d_reg[k]),   32'(m_reg[k]));
      end
    end
  end

  task automatic set_idle();
    in_valid = '0; alu_in = '0; add_in = '0; sd_in = '0; rd_in = '0;
    zero_in = 0; mr_in = 0; mw_in = 0; br_in = 0; rw_in = 0; m2r_in = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one instruction to instance k; returns 1 time unit after the capturing edge.
  task automatic issue(input int k, input logic [31:0] alu, input logic [31:0] add,
                       input logic [31:0] sd, input logic [4:0] rd, input logic mr, input logic mw,
                       input logic br, input logic z, input logic rw, input logic m2r);
    logic s;
    bit ok;
    ok = 0;
    in_valid = 3'(1 << k); alu_in = alu; add_in = add; sd_in = sd; rd_in = rd;
    mr_in = mr; mw_in = mw; br_in = br; zero_in = z; rw_in = rw; m2r_in = m2r;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      s = d_stall[k];
      @(posedge clock);
      #1;
      if (!s) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL accept timeout (latency %0d): still stalled after 20 cycles, required acceptance", k + 1);
    end
    set_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    #1 resetN = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;
    check("reset wbValid", 1, 32'(d_wv[1]), 32'd0);
    check("reset branchTarget", 1, d_bt[1], 32'd0);

    // Store then load, latency 2.
    issue(1, 32'h20, 0, 32'h12345678, 5'd0, 0, 1, 0, 0, 0, 0);
    check("store stall cycle", 1, 32'(d_stall[1]), 32'd1);
    wait_cyc(1);
    check("store completing stall", 1, 32'(d_stall[1]), 32'd0);
    issue(1, 32'h20, 0, 0, 5'd5, 1, 0, 0, 0, 1, 1);
    wait_cyc(2);
    check("load data", 1, d_rdata[1], 32'h12345678);
    check("load register", 1, 32'(d_reg[1]), 32'd5);
    check("load memToReg", 1, 32'(d_wm2r[1]), 32'd1);

    // ALU op.
    issue(1, 32'h7, 0, 0, 5'd9, 0, 0, 0, 0, 1, 0);
    check("alu no stall", 1, 32'(d_stall[1]), 32'd0);
    wait_cyc(1);
    check("alu result", 1, d_alu[1], 32'h7);
    check("alu register", 1, 32'(d_reg[1]), 32'd9);
    check("alu wbValid", 1, 32'(d_wv[1]), 32'd1);

    // Branch taken / not taken.
    issue(1, 0, 32'h400, 0, 5'd0, 0, 0, 1, 1, 0, 0);
    check("branch pcSrc", 1, 32'(d_pc[1]), 32'd1);
    check("branch target", 1, d_bt[1], 32'h400);
    wait_cyc(1);
    check("branch pcSrc drop", 1, 32'(d_pc[1]), 32'd0);
    issue(1, 0, 32'h400, 0, 5'd0, 0, 0, 1, 0, 0, 0);
    check("not-taken pcSrc", 1, 32'(d_pc[1]), 32'd0);

    // Misaligned load.
    issue(1, 32'h22, 0, 0, 5'd4, 1, 0, 0, 0, 1, 1);
    check("misaligned no stall", 1, 32'(d_stall[1]), 32'd0);
    wait_cyc(1);
    check("misaligned memError", 1, 32'(d_err[1]), 32'd1);
    check("misaligned wbRegWrite", 1, 32'(d_wrw[1]), 32'd0);
    check("misaligned wbValid", 1, 32'(d_wv[1]), 32'd1);
    wait_cyc(1);
    check("memError pulse end", 1, 32'(d_err[1]), 32'd0);

    // Address wrap: 0x404 and 0x004 hit the same word.
    issue(1, 32'h404, 0, 32'hCAFEF00D, 5'd0, 0, 1, 0, 0, 0, 0);
    issue(1, 32'h004, 0, 0, 5'd3, 1, 0, 0, 0, 1, 1);
    wait_cyc(2);
    check("wrap load data", 1, d_rdata[1], 32'hCAFEF00D);

    // Latency 1: back-to-back stores then loads.
    issue(0, 32'h0, 0, 32'hA0A00000, 5'd0, 0, 1, 0, 0, 0, 0);
    issue(0, 32'h4, 0, 32'hA1A10001, 5'd0, 0, 1, 0, 0, 0, 0);
    issue(0, 32'h8, 0, 32'hA2A20002, 5'd0, 0, 1, 0, 0, 0, 0);
    issue(0, 32'h0, 0, 0, 5'd1, 1, 0, 0, 0, 1, 1);
    issue(0, 32'h4, 0, 0, 5'd2, 1, 0, 0, 0, 1, 1);
    check("lat1 load0", 0, d_rdata[0], 32'hA0A00000);
    issue(0, 32'h8, 0, 0, 5'd3, 1, 0, 0, 0, 1, 1);
    check("lat1 load1", 0, d_rdata[0], 32'hA1A10001);
    wait_cyc(1);
    check("lat1 load2", 0, d_rdata[0], 32'hA2A20002);

    // Reset in the middle of a latency-3 store.
    issue(2, 32'h10, 0, 32'h11111111, 5'd0, 0, 1, 0, 0, 0, 0);
    issue(2, 32'h10, 0, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0, 0, 0);
    wait_cyc(1);
    resetN = 1'b0;
    #1;
    check("reset stall", 2, 32'(d_stall[2]), 32'd0);
    check("reset wbValid", 2, 32'(d_wv[2]), 32'd0);
    check("reset wbReadData", 2, d_rdata[2], 32'd0);
    check("reset wbAluResult", 2, d_alu[2], 32'd0);
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    issue(2, 32'h10, 0, 0, 5'd1, 1, 0, 0, 0, 1, 1);
    wait_cyc(3);
    check("store abandoned", 2, d_rdata[2], 32'h11111111);

    wait_cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
